object_load_scheduler: RTL and testbench

OBJECT_LOAD_SCHEDULER -- requirements
Module: object_load_scheduler

---
 rtl/object_load_scheduler.sv | 144 ++++++++++++++
 tb/tb_object_load_scheduler.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/object_load_scheduler.sv
// Object load scheduler: arbitrates two draw-record sources, drives the
// converter, and writes converted objects into slot storage.
module object_load_scheduler #(
    parameter int NUM_SLOTS = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic [1:0]                   req_valid_in,
    input  logic [1:0][86:0]             req_props_in,
    output logic [1:0]                   req_ready_out,
    output logic                         conv_valid_out,
    output logic [86:0]                  conv_props_out,
    input  logic                         conv_busy_in,
    input  logic                         conv_valid_in,
    input  logic [91:0]                  conv_obj_in,
    output logic                         wr_en_out,
    output logic [$clog2(NUM_SLOTS)-1:0] wr_addr_out,
    output logic [91:0]                  wr_data_out,
    input  logic                         clear_in,
    output logic [$clog2(NUM_SLOTS):0]   obj_count_out,
    output logic                         full_out,
    output logic                         busy_out,
    output logic                         err_timeout_out
);

    localparam int AW = $clog2(NUM_SLOTS);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        WRITE
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [86:0]     props_q;
    logic [91:0]     obj_q;
    logic [CW-1:0]   count_q;
    logic [TW-1:0]   tcnt_q;
    logic            clr_pend_q;
    logic            last_q;
    logic            err_q;

    logic            full;
    logic            can_acc;
    logic [1:0]      grant;
    logic            gsel;
    logic [86:0]     sel_props;
    logic            timeout_hit;

    assign full        = (count_q == CW'(NUM_SLOTS));
    assign timeout_hit = (tcnt_q == TW'(TIMEOUT - 1));

    // Reset gates the accept path so ready is 0 while rst_n_in is low.
    assign can_acc = rst_n_in && (state_q == IDLE) && (|req_valid_in)
                     && !full && !conv_busy_in && !clear_in && !clr_pend_q;

    always_comb begin
        grant = req_valid_in;
        if (req_valid_in == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    assign gsel      = grant[1];
    assign sel_props = req_props_in[gsel];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (can_acc && (sel_props[85:84] != 2'b00)) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (conv_valid_in) begin
                    state_d = WRITE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            props_q    <= '0;
            obj_q      <= '0;
            count_q    <= '0;
            tcnt_q     <= '0;
            clr_pend_q <= 1'b0;
            last_q     <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (can_acc) begin
                props_q <= sel_props;
                last_q  <= gsel;
            end
            if (state_q == CONVERT) begin
                tcnt_q <= tcnt_q + TW'(1);
            end else begin
                tcnt_q <= '0;
            end
            if ((state_q == CONVERT) && conv_valid_in) begin
                obj_q <= conv_obj_in;
            end
            if ((state_q == CONVERT) && !conv_valid_in && timeout_hit) begin
                err_q <= 1'b1;
            end
            // A deferred clear lands only once the in-flight write is done.
            if ((state_q == IDLE) && (clear_in || clr_pend_q)) begin
                count_q    <= '0;
                clr_pend_q <= 1'b0;
            end else begin
                if (state_q == WRITE) begin
                    count_q <= count_q + CW'(1);
                end
                if (clear_in) begin
                    clr_pend_q <= 1'b1;
                end
            end
        end
    end

    assign req_ready_out   = can_acc ? grant : 2'b00;
    assign conv_valid_out  = (state_q == CONVERT);
    assign conv_props_out  = props_q;
    assign wr_en_out       = (state_q == WRITE);
    assign wr_addr_out     = count_q[AW-1:0];
    assign wr_data_out     = obj_q;
    assign obj_count_out   = count_q;
    assign full_out        = full;
    assign busy_out        = (state_q != IDLE) || clr_pend_q;
    assign err_timeout_out = err_q;

endmodule

// File: tb/tb_object_load_scheduler.sv
// Directed bench for object_load_scheduler with four slots and a
// 64-cycle converter timeout.
module tb_object_load_scheduler;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0][86:0] req_props;
    logic [1:0]       req_ready;
    logic             conv_valid_o;
    logic [86:0]      conv_props;
    logic             conv_busy;
    logic             conv_valid_i;
    logic [91:0]      conv_obj;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [91:0]      wr_data;
    logic             clear;
    logic [2:0]       obj_count;
    logic             full;
    logic             busy;
    logic             err_to;

    int checks = 0;
    int errors = 0;
    int wn = 0;
    int viol = 0;
    logic [1:0]  wlog_a [0:63];
    logic [91:0] wlog_d [0:63];

    always #5 clk = ~clk;

    object_load_scheduler #(.NUM_SLOTS(4), .TIMEOUT(64)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .req_valid_in    (req_valid),
        .req_props_in    (req_props),
        .req_ready_out   (req_ready),
        .conv_valid_out  (conv_valid_o),
        .conv_props_out  (conv_props),
        .conv_busy_in    (conv_busy),
        .conv_valid_in   (conv_valid_i),
        .conv_obj_in     (conv_obj),
        .wr_en_out       (wr_en),
        .wr_addr_out     (wr_addr),
        .wr_data_out     (wr_data),
        .clear_in        (clear),
        .obj_count_out   (obj_count),
        .full_out        (full),
        .busy_out        (busy),
        .err_timeout_out (err_to)
    );

    always @(negedge clk) begin
        if (wr_en && wn < 64) begin
            wlog_a[wn] = wr_addr;
            wlog_d[wn] = wr_data;
        end
        if (wr_en) wn++;
        if ((int'(wr_en) + int'(|req_ready) + int'(conv_valid_o)) > 1) viol++;
    end

    function automatic logic [86:0] mk_props(input logic [1:0] id,
                                             input logic [31:0] k);
        return {1'b0, id, 52'h0, k};
    endfunction

    function automatic logic [91:0] mk_obj(input logic [31:0] k);
        return {60'h0, k};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        conv_valid_i = 1'b0;
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic serve1(input logic [91:0] obj, input logic keep);
        tick();
        if (!keep) req_valid = 2'b00;
        conv_valid_i = 1'b1;
        conv_obj = obj;
        tick();
        conv_valid_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_props[0] = mk_props(2'b01, 32'h1);
        req_props[1] = mk_props(2'b10, 32'h2);
        conv_busy = 1'b0;
        conv_valid_i = 1'b1;
        conv_obj = mk_obj(32'hdead);
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL rst_ready got %b want 00", req_ready);
        end
        checks++;
        if ({conv_valid_o, wr_en, full, busy, err_to} !== 5'b0) begin
            errors++;
            $display("FAIL rst_flags got %b want 00000",
                     {conv_valid_o, wr_en, full, busy, err_to});
        end
        checks++;
        if (obj_count !== 3'd0 || conv_props !== 87'd0 || wr_data !== 92'd0) begin
            errors++;
            $display("FAIL rst_data count %0d props %h data %h want 0",
                     obj_count, conv_props, wr_data);
        end
        req_valid = 2'b00;
        conv_valid_i = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int w0 = wn;
        req_props[0] = mk_props(2'b01, 32'h11);
        req_valid = 2'b01;
        #2;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_ready got %b want 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        #2;
        checks++;
        if (conv_valid_o !== 1'b1 || conv_props !== mk_props(2'b01, 32'h11)) begin
            errors++;
            $display("FAIL single_conv valid %b props %h", conv_valid_o, conv_props);
        end
        repeat (3) tick();
        conv_valid_i = 1'b1;
        conv_obj = mk_obj(32'h501);
        tick();
        conv_valid_i = 1'b0;
        #2;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd0 || wr_data !== mk_obj(32'h501)) begin
            errors++;
            $display("FAIL single_write en %b addr %0d data %h", wr_en, wr_addr, wr_data);
        end
        tick();
        #2;
        checks++;
        if (obj_count !== 3'd1 || (wn - w0) != 1) begin
            errors++;
            $display("FAIL single_count count %0d writes %0d want 1 1",
                     obj_count, wn - w0);
        end
    endtask

    task automatic test_round_robin();
        int w0;
        logic [1:0] eg;
        do_reset();
        w0 = wn;
        req_props[0] = mk_props(2'b01, 32'h20);
        req_props[1] = mk_props(2'b10, 32'h21);
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            #2;
            checks++;
            if (req_ready !== eg) begin
                errors++;
                $display("FAIL rr_grant%0d got %b want %b", i, req_ready, eg);
            end
            tick();
            #2;
            checks++;
            if (conv_props !== req_props[eg[1]]) begin
                errors++;
                $display("FAIL rr_props%0d got %h want %h", i, conv_props, req_props[eg[1]]);
            end
            conv_valid_i = 1'b1;
            conv_obj = mk_obj(32'h600 + i);
            tick();
            conv_valid_i = 1'b0;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wlog_a[w0+i] !== 2'(i) || wlog_d[w0+i] !== mk_obj(32'h600 + i)) begin
                errors++;
                $display("FAIL rr_write%0d addr %0d data %h", i, wlog_a[w0+i], wlog_d[w0+i]);
            end
        end
    endtask

    task automatic test_full_clear();
        int w0 = wn;
        logic ok = 1'b1;
        #2;
        checks++;
        if (full !== 1'b1 || obj_count !== 3'd4 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL full_state full %b count %0d ready %b", full, obj_count, req_ready);
        end
        repeat (3) begin
            tick();
            #2;
            if (req_ready !== 2'b00 || conv_valid_o !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL full_stall ready %b conv %b", req_ready, conv_valid_o);
        end
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #2;
        checks++;
        if (obj_count !== 3'd0 || full !== 1'b0 || req_ready !== 2'b01) begin
            errors++;
            $display("FAIL full_clear count %0d full %b ready %b want 0 0 01",
                     obj_count, full, req_ready);
        end
        serve1(mk_obj(32'h610), 1'b1);
        #2;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL full_next got %b want 10", req_ready);
        end
        serve1(mk_obj(32'h611), 1'b0);
        #2;
        checks++;
        if ((wn - w0) != 2 || wlog_a[w0] !== 2'd0 || wlog_a[w0+1] !== 2'd1
            || wlog_d[w0+1] !== mk_obj(32'h611) || obj_count !== 3'd2) begin
            errors++;
            $display("FAIL full_rest writes %0d addr %0d %0d count %0d",
                     wn - w0, wlog_a[w0], wlog_a[w0+1], obj_count);
        end
    endtask

    task automatic test_discard();
        int w0 = wn;
        logic ok = 1'b1;
        req_props[0] = mk_props(2'b00, 32'h30);
        req_valid = 2'b01;
        #2;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL discard_ready got %b want 01", req_ready);
        end
        tick();
        req_valid = 2'b00;
        repeat (3) begin
            #2;
            if (conv_valid_o !== 1'b0 || busy !== 1'b0) ok = 1'b0;
            tick();
        end
        checks++;
        if (ok !== 1'b1 || obj_count !== 3'd2 || wn != w0) begin
            errors++;
            $display("FAIL discard_idle ok %b count %0d writes %0d", ok, obj_count, wn - w0);
        end
    endtask

    task automatic test_clear_wins();
        int w0 = wn;
        req_props[1] = mk_props(2'b10, 32'h40);
        req_valid = 2'b10;
        clear = 1'b1;
        #2;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL clrwin_ready got %b want 00", req_ready);
        end
        tick();
        clear = 1'b0;
        #2;
        checks++;
        if (obj_count !== 3'd0 || req_ready !== 2'b10) begin
            errors++;
            $display("FAIL clrwin_after count %0d ready %b want 0 10", obj_count, req_ready);
        end
        serve1(mk_obj(32'h700), 1'b0);
        #2;
        checks++;
        if ((wn - w0) != 1 || wlog_a[w0] !== 2'd0 || obj_count !== 3'd1) begin
            errors++;
            $display("FAIL clrwin_write writes %0d addr %0d count %0d",
                     wn - w0, wlog_a[w0], obj_count);
        end
    endtask

    task automatic test_timeout_edge();
        req_props[0] = mk_props(2'b01, 32'h50);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        repeat (63) tick();
        conv_valid_i = 1'b1;
        conv_obj = mk_obj(32'h800);
        tick();
        conv_valid_i = 1'b0;
        #2;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd1 || wr_data !== mk_obj(32'h800)
            || err_to !== 1'b0) begin
            errors++;
            $display("FAIL toedge_write en %b addr %0d err %b want 1 1 0",
                     wr_en, wr_addr, err_to);
        end
        tick();
    endtask

    task automatic test_timeout();
        int w0 = wn;
        logic ok = 1'b1;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        #2;
        if (conv_valid_o !== 1'b1 || err_to !== 1'b0) ok = 1'b0;
        repeat (63) begin
            tick();
            #2;
            if (conv_valid_o !== 1'b1 || err_to !== 1'b0) ok = 1'b0;
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL timeout_early conv %b err %b", conv_valid_o, err_to);
        end
        tick();
        #2;
        checks++;
        if (err_to !== 1'b1 || conv_valid_o !== 1'b0 || busy !== 1'b0
            || wn != w0 || obj_count !== 3'd2) begin
            errors++;
            $display("FAIL timeout_hit err %b conv %b busy %b writes %0d count %0d",
                     err_to, conv_valid_o, busy, wn - w0, obj_count);
        end
    endtask

    task automatic test_clear_convert();
        req_props[0] = mk_props(2'b10, 32'h60);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        conv_valid_i = 1'b1;
        conv_obj = mk_obj(32'h900);
        tick();
        conv_valid_i = 1'b0;
        #2;
        checks++;
        if (wr_en !== 1'b1 || wr_addr !== 2'd2 || wr_data !== mk_obj(32'h900)) begin
            errors++;
            $display("FAIL clrconv_write en %b addr %0d data %h", wr_en, wr_addr, wr_data);
        end
        tick();
        req_valid = 2'b01;
        #2;
        checks++;
        if (obj_count !== 3'd3 || busy !== 1'b1 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL clrconv_pend count %0d busy %b ready %b want 3 1 00",
                     obj_count, busy, req_ready);
        end
        tick();
        req_valid = 2'b00;
        #2;
        checks++;
        if (obj_count !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clrconv_zero count %0d busy %b want 0 0", obj_count, busy);
        end
    endtask

    task automatic test_reset_convert();
        int w0 = wn;
        req_props[0] = mk_props(2'b01, 32'h70);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        #2;
        rst_n = 1'b0;
        conv_valid_i = 1'b1;
        req_valid = 2'b11;
        #1;
        checks++;
        if ({conv_valid_o, wr_en, busy, err_to, full} !== 5'b0 || req_ready !== 2'b00
            || conv_props !== 87'd0 || obj_count !== 3'd0) begin
            errors++;
            $display("FAIL rstconv_async flags %b ready %b props %h",
                     {conv_valid_o, wr_en, busy, err_to, full}, req_ready, conv_props);
        end
        repeat (2) @(posedge clk);
        #3;
        conv_valid_i = 1'b0;
        req_valid = 2'b00;
        rst_n = 1'b1;
        repeat (2) tick();
        #2;
        checks++;
        if (wn != w0 || conv_valid_o !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstconv_nowrite writes %0d conv %b busy %b",
                     wn - w0, conv_valid_o, busy);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_full_clear();
        test_discard();
        test_clear_wins();
        test_timeout_edge();
        test_timeout();
        test_clear_convert();
        test_reset_convert();
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL exclusive got %0d overlaps want 0", viol);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
